// File: rtl/card_pkg.sv
// Shared geometry, widths and FSM encoding for the memory-match game controller.
package card_pkg;

    localparam int NUM_CARDS = 40;
    localparam int ROWS      = 4;
    localparam int COLS      = 10;
    localparam int NUM_PAIRS = 20;

    localparam int IDX_W  = 6;
    localparam int VAL_W  = 5;
    localparam int PAIR_W = 5;
    localparam int MOVE_W = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_PICK1   = 3'd1,
        ST_PICK2   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_SHOW    = 3'd4,
        ST_WIN     = 3'd5
    } card_state_e;

    // row*10 + col built from shifts (8*row + 2*row + col)
    function automatic idx_t cursor_idx(input logic [1:0] row, input logic [3:0] col);
        return idx_t'({row, 3'b000}) + idx_t'({row, 1'b0}) + idx_t'(col);
    endfunction

endpackage

// File: rtl/card_game_ctrl_if.sv
// Button, frame, seed and renderer-facing signals of the game controller.
interface card_game_ctrl_if;
    import card_pkg::*;

    logic [5:0]           i_seed;
    logic                 i_frame;
    logic                 i_up;
    logic                 i_down;
    logic                 i_left;
    logic                 i_right;
    logic                 i_sel;
    idx_t                 i_rd_idx;
    val_t                 o_rd_val;
    idx_t                 o_cursor;
    logic [NUM_CARDS-1:0] o_face_up;
    logic [NUM_CARDS-1:0] o_matched;
    logic [PAIR_W-1:0]    o_pairs;
    logic [MOVE_W-1:0]    o_moves;
    logic                 o_busy;
    logic                 o_win;

    modport master (
        output i_seed, i_frame, i_up, i_down, i_left, i_right, i_sel, i_rd_idx,
        input  o_rd_val, o_cursor, o_face_up, o_matched, o_pairs, o_moves, o_busy, o_win
    );

    modport slave (
        input  i_seed, i_frame, i_up, i_down, i_left, i_right, i_sel, i_rd_idx,
        output o_rd_val, o_cursor, o_face_up, o_matched, o_pairs, o_moves, o_busy, o_win
    );

endinterface

// File: rtl/card_shuffle.sv
// Deck builder: stride-walks a seed through 0..39 after reset, one card per cycle,
// and serves a registered renderer read port plus a combinational pair compare.
module card_shuffle
    import card_pkg::*;
#(
    parameter int STRIDE = 17
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_seed,
    output logic       init_last,
    input  idx_t       cmp_a,
    input  idx_t       cmp_b,
    output logic       cmp_eq,
    input  idx_t       rd_idx,
    output val_t       rd_val
);

    logic [5:0] cnt_q;
    logic [5:0] p_q;
    logic [5:0] seed_mod;
    logic [5:0] p_cur;
    logic [6:0] p_sum;
    logic       running;
    val_t       deck_q [NUM_CARDS];

    assign seed_mod  = (i_seed >= 6'd40) ? i_seed - 6'd40 : i_seed;
    // Seed enters the walk directly on the first cycle; no extra load cycle.
    assign p_cur     = (cnt_q == 6'd0) ? seed_mod : p_q;
    assign p_sum     = {1'b0, p_cur} + 7'(STRIDE);
    assign running   = cnt_q < 6'(NUM_CARDS);
    assign init_last = cnt_q == 6'(NUM_CARDS - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            p_q   <= '0;
        end else if (running) begin
            cnt_q <= cnt_q + 6'd1;
            p_q   <= (p_sum >= 7'd40) ? 6'(p_sum - 7'd40) : p_sum[5:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (running && !i_rst)
            deck_q[cnt_q] <= val_t'(p_cur >> 1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            rd_val <= '0;
        else
            rd_val <= (rd_idx < 6'(NUM_CARDS)) ? deck_q[rd_idx] : '0;
    end

    assign cmp_eq = deck_q[cmp_a] == deck_q[cmp_b];

endmodule

// File: rtl/card_game_ctrl.sv
// Memory-match game FSM: cursor, face-up/matched flags, pick/compare/hold sequencing
// and score counters feeding the VGA card renderer.
module card_game_ctrl
    import card_pkg::*;
#(
    parameter int HOLD_FRAMES = 60,
    parameter int STRIDE      = 17
) (
    input logic             i_clk,
    input logic             i_rst,
    card_game_ctrl_if.slave bus
);

    localparam logic [2:0] S_INIT    = ST_INIT;
    localparam logic [2:0] S_PICK1   = ST_PICK1;
    localparam logic [2:0] S_PICK2   = ST_PICK2;
    localparam logic [2:0] S_COMPARE = ST_COMPARE;
    localparam logic [2:0] S_SHOW    = ST_SHOW;
    localparam logic [2:0] S_WIN     = ST_WIN;

    logic [2:0]           state_q;
    logic [1:0]           row_q;
    logic [3:0]           col_q;
    logic [NUM_CARDS-1:0] face_up_q;
    logic [NUM_CARDS-1:0] matched_q;
    idx_t                 pick1_q;
    idx_t                 pick2_q;
    logic [PAIR_W-1:0]    pairs_q;
    logic [MOVE_W-1:0]    moves_q;
    logic [7:0]           frame_cnt_q;

    idx_t cur;
    logic init_last;
    logic cmp_eq;
    logic pick_state;
    logic sel_ok;

    card_shuffle #(.STRIDE(STRIDE)) u_shuffle (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_seed    (bus.i_seed),
        .init_last (init_last),
        .cmp_a     (pick1_q),
        .cmp_b     (pick2_q),
        .cmp_eq    (cmp_eq),
        .rd_idx    (bus.i_rd_idx),
        .rd_val    (bus.o_rd_val)
    );

    assign cur        = cursor_idx(row_q, col_q);
    assign pick_state = (state_q == S_PICK1) || (state_q == S_PICK2);
    assign sel_ok     = bus.i_sel && pick_state && !face_up_q[cur] && !matched_q[cur];

    // Select uses cur (pre-move), so a same-cycle move never redirects the pick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state_q != S_INIT) begin
            if (bus.i_up)
                row_q <= row_q - 2'd1;
            else if (bus.i_down)
                row_q <= row_q + 2'd1;
            else if (bus.i_left)
                col_q <= (col_q == 4'd0) ? 4'(COLS - 1) : col_q - 4'd1;
            else if (bus.i_right)
                col_q <= (col_q == 4'(COLS - 1)) ? 4'd0 : col_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_INIT;
            face_up_q   <= '0;
            matched_q   <= '0;
            pick1_q     <= '0;
            pick2_q     <= '0;
            pairs_q     <= '0;
            moves_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                S_INIT: if (init_last) state_q <= S_PICK1;
                S_PICK1: if (sel_ok) begin
                    face_up_q[cur] <= 1'b1;
                    pick1_q        <= cur;
                    state_q        <= S_PICK2;
                end
                S_PICK2: if (sel_ok) begin
                    face_up_q[cur] <= 1'b1;
                    pick2_q        <= cur;
                    if (moves_q != '1) moves_q <= moves_q + 8'd1;
                    state_q        <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (cmp_eq) begin
                        face_up_q[pick1_q] <= 1'b0;
                        face_up_q[pick2_q] <= 1'b0;
                        matched_q[pick1_q] <= 1'b1;
                        matched_q[pick2_q] <= 1'b1;
                        pairs_q            <= pairs_q + 5'd1;
                        state_q <= (pairs_q == 5'(NUM_PAIRS - 1)) ? S_WIN : S_PICK1;
                    end else begin
                        frame_cnt_q <= '0;
                        state_q     <= S_SHOW;
                    end
                end
                S_SHOW: if (bus.i_frame) begin
                    if (frame_cnt_q == 8'(HOLD_FRAMES - 1)) begin
                        face_up_q[pick1_q] <= 1'b0;
                        face_up_q[pick2_q] <= 1'b0;
                        state_q            <= S_PICK1;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end
                end
                S_WIN:   state_q <= S_WIN;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign bus.o_cursor  = cur;
    assign bus.o_face_up = face_up_q;
    assign bus.o_matched = matched_q;
    assign bus.o_pairs   = pairs_q;
    assign bus.o_moves   = moves_q;
    assign bus.o_busy    = state_q == S_INIT;
    assign bus.o_win     = state_q == S_WIN;

endmodule

// File: tb/tb_card_game_ctrl.sv
// Directed bench for card_game_ctrl: shuffle reads through a scoreboard queue,
// cursor wrap/priority, match, mismatch hold, reset mid-SHOW and a full win.
module tb_card_game_ctrl;
    import card_pkg::*;

    localparam int HOLD   = 3;
    localparam int STRIDE = 17;

    localparam logic [4:0] B_UP  = 5'b10000;
    localparam logic [4:0] B_DN  = 5'b01000;
    localparam logic [4:0] B_LF  = 5'b00100;
    localparam logic [4:0] B_RT  = 5'b00010;
    localparam logic [4:0] B_SEL = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    card_game_ctrl_if bus();

    card_game_ctrl #(.HOLD_FRAMES(HOLD), .STRIDE(STRIDE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    val_t       exp_q[$];
    int         crow = 0;
    int         ccol = 0;
    logic [5:0] seed = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic val_t model_val(input logic [5:0] s, input int idx);
        int p0;
        if (idx >= NUM_CARDS) return '0;
        p0 = (s >= 40) ? int'(s) - 40 : int'(s);
        return val_t'(((p0 + STRIDE * idx) % 40) / 2);
    endfunction

    function automatic logic [39:0] bits2(input int a, input int b);
        return (40'd1 << a) | (40'd1 << b);
    endfunction

    task automatic read_chk(input int idx);
        bus.i_rd_idx = 6'(idx);
        exp_q.push_back(model_val(seed, idx));
        tick();
        check($sformatf("rd_val[%0d]", idx), 64'(bus.o_rd_val), 64'(exp_q.pop_front()));
    endtask

    task automatic press(input logic [4:0] b);
        {bus.i_up, bus.i_down, bus.i_left, bus.i_right, bus.i_sel} = b;
        tick();
        {bus.i_up, bus.i_down, bus.i_left, bus.i_right, bus.i_sel} = '0;
        if (b[4])      crow = (crow + 3) % 4;
        else if (b[3]) crow = (crow + 1) % 4;
        else if (b[2]) ccol = (ccol + 9) % 10;
        else if (b[1]) ccol = (ccol + 1) % 10;
    endtask

    task automatic goto_card(input int idx);
        for (int k = 0; k < 4 && crow != idx / 10; k++) press(B_DN);
        for (int k = 0; k < 10 && ccol != idx % 10; k++) press(B_RT);
        check($sformatf("goto %0d", idx), 64'(bus.o_cursor), 64'(idx));
    endtask

    task automatic frame_pulse();
        bus.i_frame = 1'b1;
        tick();
        bus.i_frame = 1'b0;
    endtask

    task automatic do_reset(input logic [5:0] s);
        rst = 1'b1;
        seed = s;
        bus.i_seed = s;
        tick();
        tick();
        crow = 0;
        ccol = 0;
        check("rst cursor",  64'(bus.o_cursor),  64'd0);
        check("rst face_up", 64'(bus.o_face_up), 64'd0);
        check("rst matched", 64'(bus.o_matched), 64'd0);
        check("rst pairs",   64'(bus.o_pairs),   64'd0);
        check("rst moves",   64'(bus.o_moves),   64'd0);
        check("rst rd_val",  64'(bus.o_rd_val),  64'd0);
        check("rst win",     64'(bus.o_win),     64'd0);
        check("rst busy",    64'(bus.o_busy),    64'd1);
        rst = 1'b0;
        repeat (39) tick();
        check("busy at cycle 39", 64'(bus.o_busy), 64'd1);
        tick();
        check("busy after INIT", 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int b;
        bus.i_seed = '0;
        bus.i_frame = 1'b0;
        {bus.i_up, bus.i_down, bus.i_left, bus.i_right, bus.i_sel} = '0;
        bus.i_rd_idx = '0;

        // Seed 0 deck and out-of-range reads.
        do_reset(6'd0);
        read_chk(0);
        read_chk(1);
        read_chk(2);
        read_chk(33);
        read_chk(39);
        read_chk(40);
        read_chk(63);
        check("seed0 idx2 const", 64'(model_val(6'd0, 2)), 64'd17);

        // Cursor wrap and same-cycle priority.
        press(B_LF);               check("left wrap", 64'(bus.o_cursor), 64'd9);
        press(B_UP);               check("up wrap",   64'(bus.o_cursor), 64'd39);
        press(B_DN);               check("down wrap", 64'(bus.o_cursor), 64'd9);
        press(B_UP | B_LF | B_RT); check("prio up",   64'(bus.o_cursor), 64'd39);
        press(B_DN | B_LF);        check("prio down", 64'(bus.o_cursor), 64'd9);
        press(B_RT);               check("right wrap", 64'(bus.o_cursor), 64'd0);

        // Matching pair 0/33.
        press(B_SEL);
        check("pick1 face_up", 64'(bus.o_face_up), 64'd1);
        press(B_SEL);
        check("reselect face_up", 64'(bus.o_face_up), 64'd1);
        check("reselect moves",   64'(bus.o_moves),   64'd0);
        goto_card(33);
        press(B_SEL);
        check("compare face_up", 64'(bus.o_face_up), 64'(bits2(0, 33)));
        check("compare matched", 64'(bus.o_matched), 64'd0);
        check("compare moves",   64'(bus.o_moves),   64'd1);
        tick();
        check("match matched", 64'(bus.o_matched), 64'(bits2(0, 33)));
        check("match face_up", 64'(bus.o_face_up), 64'd0);
        check("match pairs",   64'(bus.o_pairs),   64'd1);
        press(B_SEL);
        check("sel matched face_up", 64'(bus.o_face_up), 64'd0);
        check("sel matched moves",   64'(bus.o_moves),   64'd1);

        // Mismatch 1/2 held for HOLD frames; pulse during COMPARE is not counted.
        goto_card(1);
        press(B_SEL);
        goto_card(2);
        press(B_SEL);
        check("mismatch moves", 64'(bus.o_moves), 64'd2);
        bus.i_frame = 1'b1;
        tick();
        bus.i_frame = 1'b0;
        check("show face_up", 64'(bus.o_face_up), 64'(bits2(1, 2)));
        press(B_SEL | B_RT);
        check("show sel ignored", 64'(bus.o_face_up), 64'(bits2(1, 2)));
        check("show move",        64'(bus.o_cursor),  64'd3);
        frame_pulse();
        tick();
        frame_pulse();
        check("hold frame2", 64'(bus.o_face_up), 64'(bits2(1, 2)));
        tick();
        frame_pulse();
        check("hold frame3", 64'(bus.o_face_up), 64'd0);
        check("mismatch pairs", 64'(bus.o_pairs), 64'd1);

        // Select and move in one cycle: pick lands on the pre-move card.
        press(B_SEL | B_RT);
        check("selmove face_up", 64'(bus.o_face_up), 64'd8);
        check("selmove cursor",  64'(bus.o_cursor),  64'd4);
        press(B_SEL);
        tick();
        check("show2 face_up", 64'(bus.o_face_up), 64'(bits2(3, 4)));
        check("show2 moves",   64'(bus.o_moves),   64'd3);
        frame_pulse();

        // Reset mid-SHOW with a new seed.
        do_reset(6'd5);
        read_chk(0);
        check("seed5 idx0 const", 64'(model_val(6'd5, 0)), 64'd2);

        // Clear the whole board.
        for (int v = 0; v < NUM_PAIRS; v++) begin
            a = -1;
            b = -1;
            for (int i = 0; i < NUM_CARDS; i++)
                if (int'(model_val(seed, i)) == v) begin
                    if (a < 0) a = i;
                    else b = i;
                end
            goto_card(a);
            press(B_SEL);
            goto_card(b);
            press(B_SEL);
            if (v == NUM_PAIRS - 1) begin
                check("pre-win win",   64'(bus.o_win),   64'd0);
                check("pre-win pairs", 64'(bus.o_pairs), 64'd19);
            end
            tick();
        end
        check("win flag",    64'(bus.o_win),     64'd1);
        check("win pairs",   64'(bus.o_pairs),   64'd20);
        check("win matched", 64'(bus.o_matched), 64'hFF_FFFF_FFFF);
        check("win face_up", 64'(bus.o_face_up), 64'd0);
        check("win moves",   64'(bus.o_moves),   64'd20);
        press(B_SEL);
        check("win sel moves", 64'(bus.o_moves), 64'd20);
        check("win hold",      64'(bus.o_win),   64'd1);
        press(B_RT);
        check("win cursor", 64'(bus.o_cursor), 64'(crow * 10 + ccol));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
